// File: rtl/drm_metering_event_arbiter.sv
// Merges per-CU metering events into one gapped pulse stream for the DRM activator.
// Bursts are buffered in saturating per-CU counters and drained round-robin.
module drm_metering_event_arbiter #(
  parameter int unsigned NUM_CU  = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MIN_GAP = 3
) (
  input  logic              ip_core_aclk,
  input  logic              ip_core_arst,
  input  logic              drain_en,
  input  logic [NUM_CU-1:0] cu_event,
  input  logic              clr_ovf,
  output logic              metering_event,
  output logic [2:0]        grant_id,
  output logic              pending_any,
  output logic [NUM_CU-1:0] cu_overflow,
  output logic [31:0]       total_events
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned GAP_W = 4;
  localparam int unsigned TOT_W = 32;
  localparam int unsigned ROT_W = 2 * NUM_CU;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_CU];
  logic [CNT_W-1:0]   cnt_d [NUM_CU];
  logic [NUM_CU-1:0]  ovf_q, ovf_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               me_q, me_d;
  logic [TOT_W-1:0]   total_q, total_d;

  logic [NUM_CU-1:0]  nz_c;
  logic [ROT_W-1:0]   rot_c;
  logic               found_c;
  logic [IDX_W-1:0]   pick_c;
  logic               take_c;
  logic [NUM_CU-1:0]  dec_c;
  int unsigned        sum_c;

  // Rotate the non-zero map so bit 0 is the pointer, then take the first set bit.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    sum_c   = 0;
    for (int unsigned i = 0; i < NUM_CU; i++) begin
      nz_c[i] = (cnt_q[i] != '0);
    end
    rot_c = ROT_W'({nz_c, nz_c} >> ptr_q);
    for (int unsigned k = 0; k < NUM_CU; k++) begin
      if (!found_c && rot_c[k]) begin
        found_c = 1'b1;
        sum_c   = 32'(ptr_q) + k;
        if (sum_c >= NUM_CU) begin
          sum_c = sum_c - NUM_CU;
        end
        pick_c = IDX_W'(sum_c);
      end
    end
  end

  assign take_c = (state_q == S_IDLE) && drain_en && found_c;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CU; i++) begin
      dec_c[i] = take_c && (pick_c == IDX_W'(i));
    end
  end

  // Pulse sequencing: grant in IDLE, one-cycle pulse, then a forced low gap.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    gap_d   = gap_q;
    me_d    = 1'b0;
    total_d = total_q;
    case (state_q)
      S_IDLE: begin
        if (take_c) begin
          grant_d = pick_c;
          ptr_d   = (pick_c == IDX_W'(NUM_CU - 1)) ? '0 : pick_c + IDX_W'(1);
          me_d    = 1'b1;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        total_d = total_q + TOT_W'(1);
        gap_d   = GAP_W'(MIN_GAP);
        state_d = S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending counters: simultaneous inc/dec cancels; saturation drops and flags.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CU; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i] & ~clr_ovf;
      if (cu_event[i] && !dec_c[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (!cu_event[i] && dec_c[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ip_core_aclk) begin
    if (ip_core_arst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      gap_q   <= '0;
      me_q    <= 1'b0;
      total_q <= '0;
      ovf_q   <= '0;
      for (int unsigned i = 0; i < NUM_CU; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      gap_q   <= gap_d;
      me_q    <= me_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      for (int unsigned i = 0; i < NUM_CU; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign metering_event = me_q;
  assign grant_id       = grant_q;
  assign pending_any    = |nz_c;
  assign cu_overflow    = ovf_q;
  assign total_events   = total_q;

endmodule

// File: tb/tb_drm_metering_event_arbiter.sv
// Directed self-checking bench for drm_metering_event_arbiter (NUM_CU=4, CNT_W=8, MIN_GAP=3).
module tb_drm_metering_event_arbiter;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        drain_en = 1'b0;
  logic [3:0]  cu_event = '0;
  logic        clr_ovf = 1'b0;
  logic        metering_event;
  logic [2:0]  grant_id;
  logic        pending_any;
  logic [3:0]  cu_overflow;
  logic [31:0] total_events;

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt = 0;
  int cyc = 0;
  int grants[$];
  int stamps[$];

  always #5 clk = ~clk;

  drm_metering_event_arbiter #(.NUM_CU(4), .CNT_W(8), .MIN_GAP(3)) dut (
    .ip_core_aclk   (clk),
    .ip_core_arst   (arst),
    .drain_en       (drain_en),
    .cu_event       (cu_event),
    .clr_ovf        (clr_ovf),
    .metering_event (metering_event),
    .grant_id       (grant_id),
    .pending_any    (pending_any),
    .cu_overflow    (cu_overflow),
    .total_events   (total_events)
  );

  // Pulse monitor: records grant id and cycle stamp of every pulse.
  always @(posedge clk) begin
    cyc++;
    if (metering_event === 1'b1) begin
      pulse_cnt++;
      grants.push_back(int'(grant_id));
      stamps.push_back(cyc);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1; cu_event = '0; drain_en = 1'b0; clr_ovf = 1'b0;
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (metering_event !== 1'b0) begin miscompares++; $display("FAIL reset_me got %b exp 0", metering_event); end
    vectors++; if (grant_id !== 3'd0) begin miscompares++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
    vectors++; if (pending_any !== 1'b0) begin miscompares++; $display("FAIL reset_pending got %b exp 0", pending_any); end
    vectors++; if (cu_overflow !== 4'b0) begin miscompares++; $display("FAIL reset_ovf got %b exp 0000", cu_overflow); end
    vectors++; if (total_events !== 32'd0) begin miscompares++; $display("FAIL reset_total got %0d exp 0", total_events); end
  endtask

  task automatic test_single_event();
    do_reset();
    drain_en = 1'b1;
    cu_event = 4'b0100;
    @(negedge clk);
    cu_event = '0;
    vectors++; if (metering_event !== 1'b0) begin miscompares++; $display("FAIL single_early got %b exp 0", metering_event); end
    vectors++; if (pending_any !== 1'b1) begin miscompares++; $display("FAIL single_pend1 got %b exp 1", pending_any); end
    @(negedge clk);
    vectors++; if (metering_event !== 1'b1) begin miscompares++; $display("FAIL single_pulse got %b exp 1", metering_event); end
    vectors++; if (grant_id !== 3'd2) begin miscompares++; $display("FAIL single_grant got %0d exp 2", grant_id); end
    vectors++; if (pending_any !== 1'b0) begin miscompares++; $display("FAIL single_pend0 got %b exp 0", pending_any); end
    @(negedge clk);
    vectors++; if (metering_event !== 1'b0) begin miscompares++; $display("FAIL single_width got %b exp 0", metering_event); end
    vectors++; if (total_events !== 32'd1) begin miscompares++; $display("FAIL single_total got %0d exp 1", total_events); end
    repeat (4) @(negedge clk);
    vectors++; if (grant_id !== 3'd2) begin miscompares++; $display("FAIL single_hold got %0d exp 2", grant_id); end
  endtask

  task automatic test_round_robin();
    int base;
    do_reset();
    drain_en = 1'b1;
    base = grants.size();
    cu_event = 4'b1111;
    @(negedge clk);
    cu_event = '0;
    repeat (30) @(negedge clk);
    vectors++; if (grants.size() - base !== 4) begin miscompares++; $display("FAIL rr_count got %0d exp 4", grants.size() - base); end
    if (grants.size() - base == 4) begin
      for (int i = 0; i < 4; i++) begin
        vectors++; if (grants[base + i] !== i) begin miscompares++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, grants[base + i], i); end
      end
      for (int i = 1; i < 4; i++) begin
        vectors++; if (stamps[base + i] - stamps[base + i - 1] !== 5) begin miscompares++; $display("FAIL rr_spacing[%0d] got %0d exp 5", i, stamps[base + i] - stamps[base + i - 1]); end
      end
    end
    vectors++; if (total_events !== 32'd4) begin miscompares++; $display("FAIL rr_total got %0d exp 4", total_events); end
  endtask

  task automatic test_overflow();
    int p0;
    do_reset();
    p0 = pulse_cnt;
    cu_event = 4'b0010;
    repeat (300) @(negedge clk);
    cu_event = '0;
    vectors++; if (dut.cnt_q[1] !== 8'd255) begin miscompares++; $display("FAIL ovf_cnt got %0d exp 255", dut.cnt_q[1]); end
    vectors++; if (cu_overflow !== 4'b0010) begin miscompares++; $display("FAIL ovf_flag got %b exp 0010", cu_overflow); end
    vectors++; if (pulse_cnt - p0 !== 0) begin miscompares++; $display("FAIL ovf_hold got %0d exp 0", pulse_cnt - p0); end
    drain_en = 1'b1;
    repeat (255 * 5 + 20) @(negedge clk);
    vectors++; if (pulse_cnt - p0 !== 255) begin miscompares++; $display("FAIL ovf_drain got %0d exp 255", pulse_cnt - p0); end
    vectors++; if (total_events !== 32'd255) begin miscompares++; $display("FAIL ovf_total got %0d exp 255", total_events); end
    vectors++; if (pending_any !== 1'b0) begin miscompares++; $display("FAIL ovf_empty got %b exp 0", pending_any); end
    vectors++; if (cu_overflow !== 4'b0010) begin miscompares++; $display("FAIL ovf_sticky got %b exp 0010", cu_overflow); end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    vectors++; if (cu_overflow !== 4'b0000) begin miscompares++; $display("FAIL ovf_clear got %b exp 0000", cu_overflow); end
  endtask

  task automatic test_event_on_grant();
    do_reset();
    drain_en = 1'b1;
    cu_event = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    cu_event = '0;
    vectors++; if (metering_event !== 1'b1) begin miscompares++; $display("FAIL same_pulse1 got %b exp 1", metering_event); end
    vectors++; if (dut.cnt_q[0] !== 8'd1) begin miscompares++; $display("FAIL same_cnt got %0d exp 1", dut.cnt_q[0]); end
    repeat (5) @(negedge clk);
    vectors++; if (metering_event !== 1'b1) begin miscompares++; $display("FAIL same_pulse2 got %b exp 1", metering_event); end
    vectors++; if (grant_id !== 3'd0) begin miscompares++; $display("FAIL same_grant got %0d exp 0", grant_id); end
    vectors++; if (pending_any !== 1'b0) begin miscompares++; $display("FAIL same_empty got %b exp 0", pending_any); end
    repeat (10) @(negedge clk);
    vectors++; if (total_events !== 32'd2) begin miscompares++; $display("FAIL same_total got %0d exp 2", total_events); end
  endtask

  task automatic test_total_wrap();
    int p0;
    do_reset();
    force dut.total_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.total_q;
    vectors++; if (total_events !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_preload got %h exp ffffffff", total_events); end
    p0 = pulse_cnt;
    drain_en = 1'b1;
    cu_event = 4'b1000;
    @(negedge clk);
    cu_event = '0;
    repeat (10) @(negedge clk);
    vectors++; if (pulse_cnt - p0 !== 1) begin miscompares++; $display("FAIL wrap_pulses got %0d exp 1", pulse_cnt - p0); end
    vectors++; if (total_events !== 32'd0) begin miscompares++; $display("FAIL wrap_total got %h exp 00000000", total_events); end
  endtask

  task automatic test_reset_mid_gap();
    int  p0;
    bit  seen;
    do_reset();
    cu_event = 4'b1001;
    repeat (3) @(negedge clk);
    cu_event = '0;
    drain_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (metering_event === 1'b1) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL midgap_first got %b exp 1", seen); end
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    vectors++; if (pending_any !== 1'b0) begin miscompares++; $display("FAIL midgap_pending got %b exp 0", pending_any); end
    vectors++; if (metering_event !== 1'b0) begin miscompares++; $display("FAIL midgap_me got %b exp 0", metering_event); end
    vectors++; if (total_events !== 32'd0) begin miscompares++; $display("FAIL midgap_total got %0d exp 0", total_events); end
    p0 = pulse_cnt;
    repeat (30) @(negedge clk);
    vectors++; if (pulse_cnt - p0 !== 0) begin miscompares++; $display("FAIL midgap_after got %0d exp 0", pulse_cnt - p0); end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_round_robin();
    test_overflow();
    test_event_on_grant();
    test_total_wrap();
    test_reset_mid_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
